// File: rtl/tone_pkg.sv
// Shared constants for the tone bank: note codes, base-divider table, default widths.
package tone_pkg;

  localparam int DIV_W_DEF = 16;

  typedef enum logic [3:0] {
    NOTE_C  = 4'd0,
    NOTE_CS = 4'd1,
    NOTE_D  = 4'd2,
    NOTE_DS = 4'd3,
    NOTE_E  = 4'd4,
    NOTE_F  = 4'd5,
    NOTE_FS = 4'd6,
    NOTE_G  = 4'd7,
    NOTE_GS = 4'd8,
    NOTE_A  = 4'd9,
    NOTE_AS = 4'd10,
    NOTE_B  = 4'd11
  } note_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_S1,
    ST_S2
  } cmd_state_e;

  // Channel-select width; a single channel still needs one bit.
  function automatic int ch_w(int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Octave-0 divider for each semitone, in 1 MHz clock cycles.
  function automatic logic [15:0] base_div(logic [3:0] note);
    case (note)
      NOTE_C:  return 16'd61162;
      NOTE_CS: return 16'd57729;
      NOTE_D:  return 16'd54489;
      NOTE_DS: return 16'd51430;
      NOTE_E:  return 16'd48544;
      NOTE_F:  return 16'd45819;
      NOTE_FS: return 16'd43248;
      NOTE_G:  return 16'd40820;
      NOTE_GS: return 16'd38529;
      NOTE_A:  return 16'd36367;
      NOTE_AS: return 16'd34326;
      NOTE_B:  return 16'd32399;
      default: return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/tone_bank_if.sv
// Command port of the tone bank: valid/ready handshake plus the reject pulse.
interface tone_bank_if
  import tone_pkg::*;
#(
  parameter int NUM_CH = 4
) ();

  localparam int CH_W = ch_w(NUM_CH);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [CH_W-1:0] cmd_ch;
  logic [3:0]      cmd_note;
  logic [3:0]      cmd_octave;
  logic            cmd_gate;
  logic            cmd_err;

  modport master (
    output cmd_valid, cmd_ch, cmd_note, cmd_octave, cmd_gate,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_note, cmd_octave, cmd_gate,
    output cmd_ready, cmd_err
  );

endinterface

// File: rtl/tone_ch.sv
// One square-wave channel: period counter with an active and a pending divider.
module tone_ch
  import tone_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             upd_valid,
  input  logic             upd_gate,
  input  logic [DIV_W-1:0] upd_div,
  output logic             tone_out
);

  logic             gate_q, gate_d;
  logic             tone_q, tone_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] nxt_q, nxt_d;
  logic             wrap;

  assign wrap     = gate_q && (cnt_q == act_q - DIV_W'(1));
  assign tone_out = tone_q;

  always_comb begin
    gate_d = gate_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    nxt_d  = nxt_q;
    tone_d = 1'b0;

    // tone_q trails cnt_q by one cycle, so a fresh start rises the cycle after load.
    if (gate_q) begin
      tone_d = (cnt_q < (act_q >> 1));
      if (wrap) begin
        cnt_d = '0;
        act_d = nxt_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    if (upd_valid) begin
      if (!upd_gate) begin
        gate_d = 1'b0;
        cnt_d  = '0;
        tone_d = 1'b0;
      end else if (!gate_q) begin
        gate_d = 1'b1;
        cnt_d  = '0;
        act_d  = upd_div;
        nxt_d  = upd_div;
        tone_d = 1'b0;
      end else begin
        // Running channel: newest request wins, even on the wrap edge itself.
        nxt_d = upd_div;
        if (wrap) act_d = upd_div;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gate_q <= 1'b0;
      tone_q <= 1'b0;
      cnt_q  <= '0;
      act_q  <= '0;
      nxt_q  <= '0;
    end else begin
      gate_q <= gate_d;
      tone_q <= tone_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      nxt_q  <= nxt_d;
    end
  end

endmodule

// File: rtl/tone_bank.sv
// Multi-channel square-wave tone generator with a 2-stage command pipeline.
// Optional TONE_BANK_MIX_EN adds mix_out, a registered count of active tone outputs.
module tone_bank
  import tone_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int OCT_MAX = 8
) (
  input  logic              clk,
  input  logic              rstn,
  tone_bank_if.slave        cmd,
  output logic [NUM_CH-1:0] tone_out
`ifdef TONE_BANK_MIX_EN
  ,
  output logic [$clog2(NUM_CH+1)-1:0] mix_out
`endif
);

  localparam int CH_W = ch_w(NUM_CH);

  cmd_state_e       state_q, state_d;
  logic             err_q, err_d;

  logic [CH_W-1:0]  s1_ch_q, s1_ch_d;
  logic [3:0]       s1_note_q, s1_note_d;
  logic [3:0]       s1_oct_q, s1_oct_d;
  logic             s1_gate_q, s1_gate_d;

  logic [CH_W-1:0]  s2_ch_q, s2_ch_d;
  logic [15:0]      s2_base_q, s2_base_d;
  logic [3:0]       s2_oct_q, s2_oct_d;
  logic             s2_gate_q, s2_gate_d;

  logic             accept;
  logic             bad_cmd;
  logic [3:0]       oct_eff;
  logic [DIV_W-1:0] div_shift;
  logic [DIV_W-1:0] div_s2;
  logic [NUM_CH-1:0] upd_vec;

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.cmd_err   = err_q;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign bad_cmd       = (cmd.cmd_note > NOTE_B) || (32'(cmd.cmd_ch) >= NUM_CH);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    err_d     = 1'b0;
    s1_ch_d   = s1_ch_q;
    s1_note_d = s1_note_q;
    s1_oct_d  = s1_oct_q;
    s1_gate_d = s1_gate_q;
    s2_ch_d   = s2_ch_q;
    s2_base_d = s2_base_q;
    s2_oct_d  = s2_oct_q;
    s2_gate_d = s2_gate_q;

    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          // A rejected command completes the handshake but never enters the pipe.
          if (bad_cmd) begin
            err_d = 1'b1;
          end else begin
            state_d   = ST_S1;
            s1_ch_d   = cmd.cmd_ch;
            s1_note_d = cmd.cmd_note;
            s1_oct_d  = cmd.cmd_octave;
            s1_gate_d = cmd.cmd_gate;
          end
        end
      end
      ST_S1: begin
        state_d   = ST_S2;
        s2_ch_d   = s1_ch_q;
        s2_base_d = base_div(s1_note_q);
        s2_oct_d  = s1_oct_q;
        s2_gate_d = s1_gate_q;
      end
      ST_S2:   state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // S2: octave shift with saturation, then clamp so a channel never divides below 2.
  always_comb begin
    oct_eff   = (32'(s2_oct_q) > OCT_MAX) ? 4'(OCT_MAX) : s2_oct_q;
    div_shift = DIV_W'(s2_base_q) >> oct_eff;
    div_s2    = (div_shift < DIV_W'(2)) ? DIV_W'(2) : div_shift;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_INIT;
      err_q     <= 1'b0;
      s1_ch_q   <= '0;
      s1_note_q <= '0;
      s1_oct_q  <= '0;
      s1_gate_q <= 1'b0;
      s2_ch_q   <= '0;
      s2_base_q <= '0;
      s2_oct_q  <= '0;
      s2_gate_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      err_q     <= err_d;
      s1_ch_q   <= s1_ch_d;
      s1_note_q <= s1_note_d;
      s1_oct_q  <= s1_oct_d;
      s1_gate_q <= s1_gate_d;
      s2_ch_q   <= s2_ch_d;
      s2_base_q <= s2_base_d;
      s2_oct_q  <= s2_oct_d;
      s2_gate_q <= s2_gate_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign upd_vec[i] = (state_q == ST_S2) && (s2_ch_q == CH_W'(i));

    tone_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .upd_valid (upd_vec[i]),
      .upd_gate  (s2_gate_q),
      .upd_div   (div_s2),
      .tone_out  (tone_out[i])
    );
  end

`ifdef TONE_BANK_MIX_EN
  localparam int MIX_W = $clog2(NUM_CH + 1);

  logic [MIX_W-1:0] mix_q, mix_d;

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mix_d = mix_d + MIX_W'(tone_out[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mix_q <= '0;
    else       mix_q <= mix_d;
  end

  assign mix_out = mix_q;
`endif

endmodule

// File: doc/tone_bank.md
TONE_BANK -- requirements
Module: tone_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent tone channels, range 1..16.
REQ-002 SHALL have parameter DIV_W, default 16: divider and counter width, range 16..24.
REQ-003 SHALL have parameter OCT_MAX, default 8: highest octave honoured, range 0..DIV_W-2.
REQ-004 SHALL have port clk, input, 1: sole clock, 1 MHz nominal.
REQ-005 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1: command present.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid&cmd_ready at a rising edge.
REQ-008 SHALL have port cmd_ch, input, CH_W=max(1,clog2(NUM_CH)): target channel.
REQ-009 SHALL have port cmd_note, input, 4: semitone 0..11, C..B.
REQ-010 SHALL have port cmd_octave, input, 4: octave.
REQ-011 SHALL have port cmd_gate, input, 1: 1=channel on, 0=channel off.
REQ-012 SHALL have port cmd_err, output, 1: one-cycle pulse on rejected command.
REQ-013 SHALL have port tone_out, output, NUM_CH: per-channel square wave.

Function
REQ-014 SHALL compute base divider from the 12-entry table 61162, 57729, 54489, 51430, 48544, 45819, 43248, 40820, 38529, 36367, 34326, 32399, zero-extended to DIV_W.
REQ-015 SHALL compute div = base >> min(cmd_octave, OCT_MAX); octave above OCT_MAX saturates, and is not an error.
REQ-016 SHALL force div to 2 if the shift result is below 2.
REQ-017 SHALL process each accepted command in a 2-stage pipeline (S1 table lookup, S2 shift/clamp); the channel register updates on the edge ending S2, 2 cycles after acceptance.
REQ-018 SHALL deassert cmd_ready for exactly the 2 cycles following acceptance, allowing one command in flight; otherwise cmd_ready=1.
REQ-019 SHALL reject a command with cmd_note>11 or cmd_ch>=NUM_CH: it is accepted (ready handshake completes), cmd_err pulses on the following cycle, no channel state changes, and cmd_ready is not dropped.
REQ-020 SHALL have each channel run counter cnt over 0..div_act-1, wrapping to 0; tone_out=1 while cnt < div_act>>1, else 0, giving period div_act cycles.
REQ-021 SHALL have each channel hold div_act (active) and div_nxt (pending); a gated-on channel loads div_nxt into div_act only at wrap, so there is no truncated period.
REQ-022 SHALL, on a gate-on command to an idle channel, load div_act directly, set cnt=0, and start tone_out=1 the next cycle.
REQ-023 SHALL, on a gate-off command, clear tone_out and hold cnt=0 from the update edge, without waiting for wrap.
REQ-024 SHALL apply only the last pending div_nxt when two updates hit one channel before a wrap.

Reset
REQ-025 SHALL, on rstn low, asynchronously clear all channels to gate off, cnt=0, div_act=div_nxt=0, tone_out=0, cmd_err=0, cmd_ready=0, and discard the in-flight command.
REQ-026 SHALL set cmd_ready=1 on the first rising clk edge after rstn deasserts.

Configuration
REQ-027 SHALL, with macro TONE_BANK_MIX_EN defined, add output mix_out of width clog2(NUM_CH+1): registered count of tone_out bits high (1-cycle lag, 0 in reset).
REQ-028 SHALL, without TONE_BANK_MIX_EN, omit the mix_out port and its logic; all other behaviour is identical.

Structure
REQ-029 SHALL place the base-divider table constant, the note code constants, and the default DIV_W in shared package tone_pkg.
REQ-030 SHALL implement per-channel counter, gate and div_act/div_nxt logic in sub-module tone_ch, instantiated NUM_CH times.

Verification
REQ-031 SHALL cover: ch0 note 9 octave 4 gate 1 -> div 2272, tone_out[0] high 1136 and low 1136 cycles, first rise 3 cycles after accept.
REQ-032 SHALL cover: ch1 note 0 octave 15 (OCT_MAX=8) -> div 238, no cmd_err.
REQ-033 SHALL cover: note 12, then cmd_ch=NUM_CH -> cmd_err pulse each, cmd_ready stays 1, tone_out unchanged.
REQ-034 SHALL cover: ch0 running div 2272, update to note 0 octave 4 (div 3822) mid-period -> current period completes 2272 cycles, the next period is 3822.
REQ-035 SHALL cover: rstn low during S1 of an accepted command -> all outputs 0, command lost, cmd_ready=1 one edge after release.
REQ-036 SHALL cover: with TONE_BANK_MIX_EN, 3 channels gated on with equal div started together -> mix_out=3 during the high phase and 0 during the low phase.
